// File: rtl/mem_access_pkg.sv
// Shared definitions for mem_access: INST_* opcode encodings, FSM states, out_err codes.
package mem_access_pkg;

  localparam logic [5:0] INST_LB  = 6'h20;
  localparam logic [5:0] INST_LH  = 6'h21;
  localparam logic [5:0] INST_LW  = 6'h23;
  localparam logic [5:0] INST_LBU = 6'h24;
  localparam logic [5:0] INST_LHU = 6'h25;
  localparam logic [5:0] INST_SB  = 6'h28;
  localparam logic [5:0] INST_SH  = 6'h29;
  localparam logic [5:0] INST_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  function automatic logic is_subword(input logic [5:0] op);
    return (op == INST_LB) || (op == INST_LBU) || (op == INST_LH) ||
           (op == INST_LHU) || (op == INST_SB) || (op == INST_SH);
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align: little-endian lane steering for stores and extraction/extension for loads.
// Sub-word handling exists only when MEM_SUBWORD_EN is defined.
module mem_align
  import mem_access_pkg::*;
(
`ifdef MEM_SUBWORD_EN
  input  logic [5:0]  op_i,
  input  logic [1:0]  lane_i,
`endif
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

`ifdef MEM_SUBWORD_EN
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and extension keyed on opcode; word ops fall through unchanged.
  always_comb begin
    byte_s    = rdata_i[{lane_i, 3'b000} +: 8];
    half_s    = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o      = 4'hF;
    wdata_o   = st_data_i;
    ld_data_o = rdata_i;
    case (op_i)
      INST_SB:  begin be_o = 4'b0001 << lane_i; wdata_o = {4{st_data_i[7:0]}}; end
      INST_SH:  begin be_o = lane_i[1] ? 4'b1100 : 4'b0011; wdata_o = {2{st_data_i[15:0]}}; end
      INST_LB:  begin be_o = 4'b0001 << lane_i; ld_data_o = {{24{byte_s[7]}}, byte_s}; end
      INST_LBU: begin be_o = 4'b0001 << lane_i; ld_data_o = {24'd0, byte_s}; end
      INST_LH:  begin be_o = lane_i[1] ? 4'b1100 : 4'b0011; ld_data_o = {{16{half_s[15]}}, half_s}; end
      INST_LHU: begin be_o = lane_i[1] ? 4'b1100 : 4'b0011; ld_data_o = {16'd0, half_s}; end
      default:  ;
    endcase
  end
`else
  assign be_o      = 4'hF;
  assign wdata_o   = st_data_i;
  assign ld_data_o = rdata_i;
`endif

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage (IDLE/REQ/RESP) with ack timeout and misalignment traps.
// Optional MEM_SUBWORD_EN adds byte/halfword loads and stores.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] alu_rslt,
  input  logic [31:0] st_data,
  input  logic [4:0]  rd_in,
  input  logic        wb_en_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [1:0]  out_err
);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        ld_we_q;
  logic        acc_s, is_mem_s, is_st_s, mis_s, pass_we_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, ld_data_s;

  // rst gates in_ready so nothing is accepted while reset is held.
  assign in_ready = rst && ((state_q == IDLE) || ((state_q == RESP) && out_ready));
  assign acc_s    = in_valid && in_ready;

`ifdef MEM_SUBWORD_EN
  logic [5:0] op_q;
  logic [1:0] lane_q;

  // Remember opcode and lane so the load result can be extracted at ack time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= 6'd0;
      lane_q <= 2'd0;
    end else if (acc_s) begin
      op_q   <= opcode;
      lane_q <= alu_rslt[1:0];
    end
  end

  mem_align u_align (
    .op_i      ((state_q == REQ) ? op_q : opcode),
    .lane_i    ((state_q == REQ) ? lane_q : alu_rslt[1:0]),
    .st_data_i (st_data),
    .rdata_i   (mem_rdata),
    .be_o      (be_s),
    .wdata_o   (wdata_s),
    .ld_data_o (ld_data_s)
  );
`else
  mem_align u_align (
    .st_data_i (st_data),
    .rdata_i   (mem_rdata),
    .be_o      (be_s),
    .wdata_o   (wdata_s),
    .ld_data_o (ld_data_s)
  );
`endif

  // Classify the incoming instruction: memory op, store, misaligned.
  always_comb begin
    is_st_s   = (opcode == INST_SW);
    is_mem_s  = (opcode == INST_LW) || is_st_s;
    mis_s     = is_mem_s && (alu_rslt[1:0] != 2'b00);
`ifdef MEM_SUBWORD_EN
    pass_we_s = wb_en_in;
    case (opcode)
      INST_LB, INST_LBU: begin is_mem_s = 1'b1; mis_s = 1'b0; end
      INST_LH, INST_LHU: begin is_mem_s = 1'b1; mis_s = alu_rslt[0]; end
      INST_SB:           begin is_mem_s = 1'b1; is_st_s = 1'b1; mis_s = 1'b0; end
      INST_SH:           begin is_mem_s = 1'b1; is_st_s = 1'b1; mis_s = alu_rslt[0]; end
      default:           ;
    endcase
`else
    pass_we_s = wb_en_in && !is_subword(opcode);
`endif
  end

  // Stage FSM with all bus and writeback outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      ld_we_q   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_rd    <= 5'd0;
      out_we    <= 1'b0;
      out_err   <= ERR_NONE;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if ((state_q == IDLE) || out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
          if (acc_s) begin
            out_rd <= rd_in;
            if (is_mem_s && !mis_s) begin
              state_q   <= REQ;
              cnt_q     <= 8'd0;
              ld_we_q   <= wb_en_in && !is_st_s;
              mem_req   <= 1'b1;
              mem_we    <= is_st_s;
              mem_be    <= be_s;
              mem_addr  <= {alu_rslt[31:2], 2'b00};
              mem_wdata <= wdata_s;
            end else begin
              state_q   <= RESP;
              out_valid <= 1'b1;
              out_data  <= alu_rslt;
              out_we    <= is_mem_s ? 1'b0 : pass_we_s;
              out_err   <= is_mem_s ? ERR_MISALIGN : ERR_NONE;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_q   <= RESP;
            out_valid <= 1'b1;
            out_data  <= ld_data_s;
            out_we    <= ld_we_q;
            out_err   <= ERR_NONE;
          end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_q   <= RESP;
            out_valid <= 1'b1;
            out_data  <= 32'd0;
            out_we    <= 1'b0;
            out_err   <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, the number of cycles to wait for mem_ack before flagging a bus error (range 1..255).
REQ-002 SHALL have ports, one per line, clock and reset first:
 clk  in  1  sole clock; all state updates on rising edge
 rst  in  1  reset, asynchronous and active-low (one clock; reset is asynchronous and active-low)
 in_valid  in  1  ALU-stage result valid
 in_ready  out  1  stage can accept
 opcode  in  6  instruction opcode, INST_* encoding
 alu_rslt  in  32  ALU result: effective address for loads/stores, writeback value otherwise
 st_data  in  32  rt register value for stores
 rd_in  in  5  destination register
 wb_en_in  in  1  instruction writes a register
 mem_req  out  1  memory request, held until mem_ack
 mem_we  out  1  write request
 mem_be  out  4  byte enables, bit i = byte lane i
 mem_addr  out  32  word address, bits [1:0] always 0
 mem_wdata  out  32  lane-steered store data
 mem_ack  in  1  memory completes request this cycle
 mem_rdata  in  32  read data, valid with mem_ack
 out_valid  out  1  writeback record valid
 out_ready  in  1  writeback accepts
 out_data  out  32  writeback value
 out_rd  out  5  destination register
 out_we  out  1  register write enable
 out_err  out  2  0 none, 1 misaligned, 2 bus timeout

Function
REQ-003 SHALL accept an input when in_valid && in_ready; in_ready SHALL be 1 only in state IDLE, or in state RESP while out_ready is 1.
REQ-004 SHALL implement states IDLE, REQ and RESP.
REQ-005 For a non-memory opcode, SHALL go IDLE->RESP and present out_data=alu_rslt and out_we=wb_en_in the next cycle (latency 1).
REQ-006 For LW/SW with alu_rslt[1:0]==0, SHALL enter REQ and assert mem_req the cycle after acceptance, with mem_addr={alu_rslt[31:2],2'b00}.
REQ-006a In REQ, SW SHALL drive mem_be=4'hF.
REQ-007 SHALL hold mem_req, mem_we, mem_be, mem_addr and mem_wdata stable until the cycle mem_ack=1, then SHALL move REQ->RESP.
REQ-008 On a load ack, SHALL register the lane-extracted, extended mem_rdata into out_data.
REQ-008a A store SHALL reach RESP with out_we=0.
REQ-009 SHALL keep a cycle counter in REQ that clears on entry; if mem_ack has not arrived after ACK_TIMEOUT cycles, SHALL drop mem_req, move to RESP with out_err=2 and out_we=0.
REQ-010 For a misaligned access (LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0), SHALL make no memory request and SHALL go IDLE->RESP with out_err=1 and out_we=0.
REQ-011 In RESP, SHALL hold out_valid=1 and out_* stable until out_ready.
REQ-011a When out_ready=1 and a new input is accepted in the same cycle, SHALL go directly to the new input's next state with no bubble.
REQ-011b When out_ready=1 and no input is accepted, SHALL return to IDLE.
REQ-012 Byte lanes SHALL be little-endian: lane = addr[1:0] for bytes, {addr[1],1'b0} for halfwords.
REQ-012a Store data SHALL be replicated across lanes; only mem_be selects the written bytes.
REQ-013 A mem_ack seen outside REQ SHALL be ignored.

Reset
REQ-014 While rst=0, SHALL force state IDLE and the timeout counter to 0.
REQ-014a While rst=0, SHALL drive mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, out_valid=0, out_data=0, out_rd=0, out_we=0 and out_err=0.
REQ-014b While rst=0, in_ready SHALL be 0.
REQ-015 Reset asserted mid-request SHALL abandon the request immediately; a later mem_ack SHALL be ignored per REQ-013.

Configuration
REQ-016 With MEM_SUBWORD_EN defined, SHALL support LB, LBU, LH, LHU, SB and SH with lane steering, sign/zero extension and byte enables per REQ-012.
REQ-016a Without MEM_SUBWORD_EN, these opcodes SHALL be treated as non-memory pass-through with out_we=0, and no sub-word logic SHALL be synthesised.

Structure
REQ-017 Opcode constants SHALL come from the shared INST.v include.
REQ-017a The state encodings and the out_err codes SHALL be defined in a shared package/include, MEM_DEFS.
REQ-018 Lane steering and extension SHALL live in one combinational sub-module, mem_align, instantiated once.

Verification
REQ-019 LW addr 0x100, mem_ack 3 cycles after mem_req, rdata 0xDEADBEEF -> mem_addr 0x100, mem_be F, out_data 0xDEADBEEF, out_we 1, out_err 0.
REQ-020 SB addr 0x203, st_data 0x000000AB (MEM_SUBWORD_EN) -> mem_addr 0x200, mem_be 4'b1000, mem_wdata 0xABABABAB, out_we 0.
REQ-021 LB addr 0x2, rdata 0x00800000 -> out_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-022 LW addr 0x102 -> no mem_req, out_err 1, out_we 0, latency 1.
REQ-023 ACK_TIMEOUT=4, never ack -> mem_req drops after 4 cycles, out_err 2; rst pulsed mid-REQ -> all outputs 0, later mem_ack ignored.
REQ-024 Back-to-back ADDs with out_ready held 1 -> one result per cycle; out_ready low for 3 cycles -> out_data held and in_ready 0.
